pc_fetch_controller: RTL

- Sequences the ProgramCounter register: produces its NewPC and WriteEnable each cycle and drives IF/ID pipeline-register control.
- Arbitrates between sequential fetch, branch redirect, jump, jump-register, load-use stall and halt requests.
- Keeps saturating stall and redirect counters for debug.
- Sits between the hazard/branch logic in ID/EX and the ProgramCounter and IF/ID register.

---
 rtl/pc_fetch_controller.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_controller.sv
// Next-PC sequencer: chooses between sequential fetch, branch/jump redirects,
// load-use stalls and halt, and drives ProgramCounter and IF/ID control.
// Debug counters record stall cycles and redirects, saturating at all-ones.
module pc_fetch_controller #(
  parameter int unsigned ADDR_MAX     = 252,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      PC,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic             JumpReg,
  input  logic [31:0]      RegTarget,
  input  logic             Halt,
  output logic [31:0]      NewPC,
  output logic             PCWriteEnable,
  output logic             IFIDWriteEnable,
  output logic             IFIDFlush,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] RedirectCount
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [1:0]       FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_s;
  logic [1:0]       flush_cnt_r;
  logic [1:0]       flush_cnt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] redir_cnt_r;
  logic             stall_inc_s;
  logic             redir_inc_s;
  logic             redirect_s;
  logic [31:0]      redirect_target_s;
  logic [31:0]      seq_pc_s;

  // Word-align an address and wrap anything past the top of instruction memory to 0.
  function automatic logic [31:0] legalize(input logic [31:0] addr);
    logic [31:0] aligned;
    aligned = {addr[31:2], 2'b00};
    if (aligned > 32'(ADDR_MAX)) begin
      legalize = 32'd0;
    end else begin
      legalize = aligned;
    end
  endfunction

  // Redirect source selection: branch is oldest, then jump-register, then jump.
  always_comb begin
    redirect_s        = BranchTaken | JumpReg | Jump;
    redirect_target_s = JumpTarget;
    seq_pc_s          = legalize(PC + 32'd4);
    if (BranchTaken) begin
      redirect_target_s = BranchTarget;
    end else if (JumpReg) begin
      redirect_target_s = RegTarget;
    end else begin
      redirect_target_s = JumpTarget;
    end
  end

  // Next-state and output decode; a redirect outranks a stall because the branch is older.
  always_comb begin
    state_s         = state_r;
    flush_cnt_s     = flush_cnt_r;
    NewPC           = 32'd0;
    PCWriteEnable   = 1'b0;
    IFIDWriteEnable = 1'b0;
    IFIDFlush       = 1'b1;
    Halted          = 1'b0;
    stall_inc_s     = 1'b0;
    redir_inc_s     = 1'b0;
    case (state_r)
      HOLD: begin
        state_s     = RUN;
        flush_cnt_s = 2'd0;
      end
      RUN, FLUSH: begin
        if (Halt) begin
          NewPC       = PC;
          state_s     = HALT;
          flush_cnt_s = 2'd0;
        end else if (redirect_s) begin
          NewPC           = legalize(redirect_target_s);
          PCWriteEnable   = 1'b1;
          IFIDWriteEnable = 1'b1;
          IFIDFlush       = 1'b1;
          redir_inc_s     = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_s     = FLUSH;
            flush_cnt_s = FLUSH_LOAD;
          end else begin
            state_s     = RUN;
            flush_cnt_s = 2'd0;
          end
        end else if (state_r == FLUSH) begin
          // Wrong-path fetches keep moving but are squashed; stalls do not apply here.
          NewPC           = seq_pc_s;
          PCWriteEnable   = 1'b1;
          IFIDWriteEnable = 1'b1;
          IFIDFlush       = 1'b1;
          flush_cnt_s     = flush_cnt_r - 2'd1;
          if (flush_cnt_r <= 2'd1) begin
            state_s = RUN;
          end else begin
            state_s = FLUSH;
          end
        end else if (Stall) begin
          NewPC       = PC;
          IFIDFlush   = 1'b0;
          stall_inc_s = 1'b1;
        end else begin
          NewPC           = seq_pc_s;
          PCWriteEnable   = 1'b1;
          IFIDWriteEnable = 1'b1;
          IFIDFlush       = 1'b0;
        end
      end
      HALT: begin
        NewPC  = PC;
        Halted = 1'b1;
      end
      default: begin
        state_s     = HOLD;
        flush_cnt_s = 2'd0;
      end
    endcase
  end

  // State and flush-counter registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r     <= HOLD;
      flush_cnt_r <= 2'd0;
    end else begin
      state_r     <= state_s;
      flush_cnt_r <= flush_cnt_s;
    end
  end

  // Saturating debug counters.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      redir_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (redir_inc_s && (redir_cnt_r != CNT_MAX)) begin
        redir_cnt_r <= redir_cnt_r + CNT_W'(1);
      end
    end
  end

  assign StallCount    = stall_cnt_r;
  assign RedirectCount = redir_cnt_r;

endmodule
